joy_answer_arbiter: RTL and testbench

- Front-end stage between the raw 8-bit active-low joystick/remote buttons (min_hex_joy) and the answer-checking/scoring logic.
- Synchronizes and debounces the button vector, then arbitrates the first valid press.
- Emits a single registered one-cycle answer event carrying choice (1-4) and player (1-2).
- Locks out further events until all buttons are released, so one held press scores at most once.

---
 rtl/quiz_pkg.sv | 49 ++++
 rtl/joy_debounce.sv | 49 ++++
 rtl/joy_answer_arbiter.sv | 85 ++++++++
 tb/tb_joy_answer_arbiter.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/quiz_pkg.sv
// Shared definitions for the quiz answer front end: FSM encoding, idle
// button pattern, player ids and the button-to-answer mapping.
package quiz_pkg;

    localparam int unsigned JOY_W    = 8;
    localparam int unsigned CHOICE_W = 4;
    localparam int unsigned PLAYER_W = 2;

    typedef enum logic [1:0] {
        WAIT_REL = 2'd0,
        ARMED    = 2'd1,
        LOCK     = 2'd2
    } arb_state_t;

    localparam logic [JOY_W-1:0]    JOY_IDLE = 8'hFF;
    localparam logic [PLAYER_W-1:0] PLAYER_1 = 2'd1;
    localparam logic [PLAYER_W-1:0] PLAYER_2 = 2'd2;

    typedef struct packed {
        logic [CHOICE_W-1:0] choice;
        logic [PLAYER_W-1:0] player;
    } answer_t;

    // Indexed by button bit number; the upper nibble belongs to player 1.
    localparam answer_t BTN_MAP [JOY_W] = '{
        '{choice: 4'd4, player: PLAYER_2},
        '{choice: 4'd3, player: PLAYER_2},
        '{choice: 4'd2, player: PLAYER_2},
        '{choice: 4'd1, player: PLAYER_2},
        '{choice: 4'd4, player: PLAYER_1},
        '{choice: 4'd3, player: PLAYER_1},
        '{choice: 4'd2, player: PLAYER_1},
        '{choice: 4'd1, player: PLAYER_1}
    };

    // Map an active-low button vector to its answer; meaningful only when
    // exactly one bit is low.
    function automatic answer_t decode_button(input logic [JOY_W-1:0] btn);
        answer_t ans;
        ans = '0;
        for (int i = 0; i < int'(JOY_W); i++) begin
            if (!btn[i]) begin
                ans = BTN_MAP[i];
            end
        end
        return ans;
    endfunction

endpackage

// File: rtl/joy_debounce.sv
// Two-flop synchronizer followed by a hold-time debouncer for the raw
// active-low button vector.
module joy_debounce
    import quiz_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned CNT_W           = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] raw,
    output logic [7:0] stable
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [7:0]       q1;
    logic [7:0]       q2;
    logic [7:0]       cand;
    logic [CNT_W-1:0] cnt;

    // Bring the asynchronous pins into the clk domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q1 <= JOY_IDLE;
            q2 <= JOY_IDLE;
        end else begin
            q1 <= raw;
            q2 <= q1;
        end
    end

    // Accept a new vector only after it has held unchanged long enough.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cand   <= JOY_IDLE;
            cnt    <= '0;
            stable <= JOY_IDLE;
        end else if (q2 != cand) begin
            cand <= q2;
            cnt  <= '0;
        end else if (cnt < CNT_MAX) begin
            cnt <= cnt + CNT_W'(1);
        end else begin
            stable <= cand;
        end
    end

endmodule

// File: rtl/joy_answer_arbiter.sv
// Debounced joystick answer arbiter: first stable press while armed yields
// one answer event; further events wait for a full release.
module joy_answer_arbiter
    import quiz_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned CNT_W           = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] min_hex_joy,
    input  logic       arm,
    output logic       ans_valid,
    output logic [3:0] ans_choice,
    output logic [1:0] ans_player,
    output logic       ans_conflict,
    output logic       busy
);

    logic [7:0] stable;
    logic       idle;
    logic       one_low;
    answer_t    press;
    arb_state_t state;

    joy_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_debounce (
        .clk    (clk),
        .rst_n  (rst_n),
        .raw    (min_hex_joy),
        .stable (stable)
    );

    assign idle    = (stable == JOY_IDLE);
    assign one_low = $onehot(~stable);
    assign press   = decode_button(stable);

    // Arbitration FSM with registered event pulses, answer fields and busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= WAIT_REL;
            busy         <= 1'b1;
            ans_valid    <= 1'b0;
            ans_conflict <= 1'b0;
            ans_choice   <= '0;
            ans_player   <= '0;
        end else begin
            ans_valid    <= 1'b0;
            ans_conflict <= 1'b0;
            case (state)
                WAIT_REL: begin
                    if (idle) begin
                        state <= ARMED;
                        busy  <= 1'b0;
                    end
                end
                ARMED: begin
                    if (arm && !idle) begin
                        if (one_low) begin
                            ans_valid  <= 1'b1;
                            ans_choice <= press.choice;
                            ans_player <= press.player;
                        end else begin
                            ans_conflict <= 1'b1;
                        end
                        state <= LOCK;
                        busy  <= 1'b1;
                    end
                end
                LOCK: begin
                    if (idle) begin
                        state <= WAIT_REL;
                    end
                end
                default: begin
                    state <= WAIT_REL;
                    busy  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_joy_answer_arbiter.sv
// Self-checking bench for joy_answer_arbiter: directed table, hand-written
// corner sequences and random pins checked cycle by cycle against a model.
module tb_joy_answer_arbiter;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] pins = 8'hFF;
    logic       arm = 1'b0;
    logic       ans_valid;
    logic [3:0] ans_choice;
    logic [1:0] ans_player;
    logic       ans_conflict;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    joy_answer_arbiter #(
        .DEBOUNCE_CYCLES (D),
        .CNT_W           (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .min_hex_joy  (pins),
        .arm          (arm),
        .ans_valid    (ans_valid),
        .ans_choice   (ans_choice),
        .ans_player   (ans_player),
        .ans_conflict (ans_conflict),
        .busy         (busy)
    );

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: pin samples history, "stable" = last value seen for
    // D+1 consecutive synchronized samples, and an arbiter that needs a
    // number of idle-stable cycles before it re-arms.
    logic [7:0] hist [0:D+1];
    logic [7:0] m_stable;
    bit         m_armed;
    int         m_need;
    bit         m_valid;
    bit         m_conflict;
    int         m_choice;
    int         m_player;

    always @(posedge clk or negedge rst_n) begin : model
        int  lows;
        int  idx;
        bit  same;
        if (!rst_n) begin
            for (int i = 0; i <= D + 1; i++) hist[i] = 8'hFF;
            m_stable   = 8'hFF;
            m_armed    = 1'b0;
            m_need     = 1;
            m_valid    = 1'b0;
            m_conflict = 1'b0;
            m_choice   = 0;
            m_player   = 0;
        end else begin
            m_valid    = 1'b0;
            m_conflict = 1'b0;
            if (m_armed) begin
                if (arm && m_stable != 8'hFF) begin
                    lows = $countones(~m_stable);
                    if (lows == 1) begin
                        idx = 0;
                        for (int i = 0; i < 8; i++) if (!m_stable[i]) idx = i;
                        m_valid  = 1'b1;
                        m_choice = 4 - (idx % 4);
                        m_player = (idx >= 4) ? 1 : 2;
                    end else begin
                        m_conflict = 1'b1;
                    end
                    m_armed = 1'b0;
                    m_need  = 2;
                end
            end else if (m_stable == 8'hFF) begin
                m_need--;
                if (m_need == 0) m_armed = 1'b1;
            end
            same = 1'b1;
            for (int i = 2; i <= D + 1; i++) if (hist[i] != hist[1]) same = 1'b0;
            if (same) m_stable = hist[1];
            for (int i = D + 1; i >= 1; i--) hist[i] = hist[i-1];
            hist[0] = pins;
        end
    end

    // Lockstep comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (rst_n && chk_en) begin
            check("valid", int'(ans_valid), int'(m_valid));
            check("conflict", int'(ans_conflict), int'(m_conflict));
            check("choice", int'(ans_choice), m_choice);
            check("player", int'(ans_player), m_player);
            check("busy", int'(busy), int'(!m_armed));
            check("pulse_excl", int'(ans_valid && ans_conflict), 0);
        end
    end

    task automatic run(input logic [7:0] p, input logic a, input int cycles,
                       output int nv, output int nc);
        pins = p;
        arm  = a;
        nv   = 0;
        nc   = 0;
        repeat (cycles) begin
            @(negedge clk);
            nv += int'(ans_valid);
            nc += int'(ans_conflict);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_valid"}, int'(ans_valid), 0);
        check({tag, "_conflict"}, int'(ans_conflict), 0);
        check({tag, "_choice"}, int'(ans_choice), 0);
        check({tag, "_player"}, int'(ans_player), 0);
        check({tag, "_busy"}, int'(busy), 1);
    endtask

    typedef struct {
        logic [7:0] pins;
        logic       arm;
        int         cycles;
        int         exp_v;
        int         exp_c;
        int         exp_choice;
        int         exp_player;
    } vec_t;

    vec_t tbl [13];

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "timeout");
    end

    initial begin
        int nv;
        int nc;
        int lat;
        int cyc;

        tbl[0]  = '{8'hFF, 1'b1, 10, 0, 0, 0, 0};
        tbl[1]  = '{8'hDF, 1'b1, 20, 1, 0, 3, 1};
        tbl[2]  = '{8'hFF, 1'b1, 12, 0, 0, 3, 1};
        tbl[3]  = '{8'hF7, 1'b1,  3, 0, 0, 3, 1};
        tbl[4]  = '{8'hFF, 1'b1, 12, 0, 0, 3, 1};
        tbl[5]  = '{8'hFE, 1'b1, 15, 1, 0, 4, 2};
        tbl[6]  = '{8'hFE, 1'b0,  3, 0, 0, 4, 2};
        tbl[7]  = '{8'hFE, 1'b1, 10, 0, 0, 4, 2};
        tbl[8]  = '{8'hFF, 1'b1, 12, 0, 0, 4, 2};
        tbl[9]  = '{8'hFB, 1'b1, 15, 1, 0, 2, 2};
        tbl[10] = '{8'hFF, 1'b1, 12, 0, 0, 2, 2};
        tbl[11] = '{8'h7E, 1'b1, 15, 0, 1, 2, 2};
        tbl[12] = '{8'hFF, 1'b1, 12, 0, 0, 2, 2};

        pins  = 8'hFF;
        arm   = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        check("reset_stable", int'(dut.u_debounce.stable), 8'hFF);
        rst_n  = 1'b1;
        chk_en = 1'b1;

        for (int i = 0; i < 13; i++) begin
            run(tbl[i].pins, tbl[i].arm, tbl[i].cycles, nv, nc);
            check($sformatf("vec%0d_nvalid", i), nv, tbl[i].exp_v);
            check($sformatf("vec%0d_nconflict", i), nc, tbl[i].exp_c);
            check($sformatf("vec%0d_choice", i), int'(ans_choice), tbl[i].exp_choice);
            check($sformatf("vec%0d_player", i), int'(ans_player), tbl[i].exp_player);
            if (i == 0) check("armed_busy", int'(busy), 0);
            if (i == 1) check("locked_busy", int'(busy), 1);
            if (i == 3) check("glitch_stable", int'(dut.u_debounce.stable), 8'hFF);
        end

        // Press latency from pin change to answer pulse.
        pins = 8'hDF;
        lat  = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (ans_valid && lat == 0) lat = k;
        end
        check("latency", lat, D + 4);
        run(8'hFF, 1'b1, 12, nv, nc);

        // Held press while disarmed is reported the cycle after arm rises.
        run(8'hBF, 1'b0, 15, nv, nc);
        check("disarmed_nvalid", nv, 0);
        arm = 1'b1;
        @(negedge clk);
        check("arm_rise_valid", int'(ans_valid), 1);
        check("arm_rise_choice", int'(ans_choice), 2);
        check("arm_rise_player", int'(ans_player), 1);
        run(8'hFF, 1'b1, 12, nv, nc);

        // Button held through reset release, disarmed; then release and re-press.
        pins  = 8'hEF;
        arm   = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_vals("held_rst");
        rst_n = 1'b1;
        run(8'hEF, 1'b0, 20, nv, nc);
        check("held_nvalid", nv + nc, 0);
        run(8'hFF, 1'b1, 12, nv, nc);
        run(8'hEF, 1'b1, 15, nv, nc);
        check("repress_nvalid", nv, 1);
        check("repress_choice", int'(ans_choice), 4);
        check("repress_player", int'(ans_player), 1);
        run(8'hFF, 1'b1, 12, nv, nc);

        // Reset asserted mid-debounce.
        run(8'hDF, 1'b1, 4, nv, nc);
        #1 rst_n = 1'b0;
        #1;
        check_reset_vals("middeb_rst");
        check("middeb_stable", int'(dut.u_debounce.stable), 8'hFF);
        @(negedge clk);
        pins  = 8'hFF;
        rst_n = 1'b1;
        run(8'hFF, 1'b1, 12, nv, nc);

        // Reset asserted while the answer pulse is high.
        pins = 8'h7F;
        lat  = 0;
        for (int k = 1; k <= 20 && lat == 0; k++) begin
            @(negedge clk);
            if (ans_valid) lat = k;
        end
        check("inflight_seen", lat, D + 4);
        #1 rst_n = 1'b0;
        #1;
        check_reset_vals("inflight_rst");
        @(negedge clk);
        pins  = 8'hFF;
        rst_n = 1'b1;
        run(8'hFF, 1'b1, 12, nv, nc);

        // Random pins and arm, checked every cycle by the model.
        cyc = 0;
        while (cyc < 3000) begin
            int r;
            int h;
            logic [7:0] p;
            r = int'($urandom_range(0, 9));
            if (r < 4) begin
                p = 8'hFF;
            end else if (r < 8) begin
                p = ~(8'h01 << $urandom_range(0, 7));
            end else if (r == 8) begin
                p = ~((8'h01 << $urandom_range(0, 7)) | (8'h01 << $urandom_range(0, 7)));
            end else begin
                p = 8'($urandom);
            end
            h = int'($urandom_range(1, 12));
            run(p, ($urandom_range(0, 4) != 0), h, nv, nc);
            cyc += h;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
